// File: rtl/agu_encode.sv
// Address-stream compressor: folds an arithmetic-progression address stream back
// into the (ini, fin, param, len) descriptor that would regenerate it.
module agu_encode #(
  parameter int W  = 32,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  addr_in,
  input  logic          addr_valid,
  input  logic          addr_last,
  output logic          addr_ready,
  output logic [W-1:0]  desc_ini,
  output logic [W-1:0]  desc_fin,
  output logic [W-1:0]  desc_param,
  output logic [LW-1:0] desc_len,
  output logic          desc_err,
  output logic          desc_valid,
  input  logic          desc_ready
);

  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    SECOND = 2'd1,
    RUN    = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  ini_q, ini_d;
  logic [W-1:0]  fin_q, fin_d;
  logic [W-1:0]  param_q, param_d;
  logic [W-1:0]  prev_q, prev_d;
  logic [LW-1:0] len_q, len_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;

  logic          beat_acc;
  logic [LW-1:0] len_inc;

  // Ready depends on state alone so upstream never sees a combinational path.
  assign addr_ready = (state_q != OUT);
  assign beat_acc   = addr_valid && addr_ready;
  assign len_inc    = (len_q == {LW{1'b1}}) ? len_q : len_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ini_d   = ini_q;
    fin_d   = fin_q;
    param_d = param_q;
    prev_d  = prev_q;
    len_d   = len_q;
    err_d   = err_q;
    valid_d = valid_q;

    case (state_q)
      FIRST: begin
        if (beat_acc) begin
          ini_d   = addr_in;
          fin_d   = addr_in;
          prev_d  = addr_in;
          param_d = '0;
          len_d   = {{(LW-1){1'b0}}, 1'b1};
          err_d   = 1'b0;
          if (addr_last) begin
            state_d = OUT;
            valid_d = 1'b1;
          end else begin
            state_d = SECOND;
          end
        end
      end
      SECOND: begin
        if (beat_acc) begin
          param_d = addr_in - prev_q;
          prev_d  = addr_in;
          fin_d   = addr_in;
          len_d   = len_inc;
          if (addr_last) begin
            state_d = OUT;
            valid_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (beat_acc) begin
          // Stride stays at the first-pair value; any deviation only flags err.
          if (addr_in != prev_q + param_q) err_d = 1'b1;
          prev_d = addr_in;
          fin_d  = addr_in;
          len_d  = len_inc;
          if (addr_last) begin
            state_d = OUT;
            valid_d = 1'b1;
          end
        end
      end
      OUT: begin
        if (desc_ready) begin
          state_d = FIRST;
          valid_d = 1'b0;
        end
      end
      default: state_d = FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FIRST;
      ini_q   <= '0;
      fin_q   <= '0;
      param_q <= '0;
      prev_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ini_q   <= ini_d;
      fin_q   <= fin_d;
      param_q <= param_d;
      prev_q  <= prev_d;
      len_q   <= len_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign desc_ini   = ini_q;
  assign desc_fin   = fin_q;
  assign desc_param = param_q;
  assign desc_len   = len_q;
  assign desc_err   = err_q;
  assign desc_valid = valid_q;

endmodule

// File: doc/agu_encode.md
AGU_ENCODE -- requirements
Module: agu_encode

Interface
REQ-001 Parameter W, default 32: address/stride width.
REQ-002 Parameter LW, default 16: beat-count width.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 addr_in  in  W  address beat, an arithmetic-progression element.
REQ-006 addr_valid  in  1  addr_in valid.
REQ-007 addr_last  in  1  final beat of current sequence; qualified by addr_valid.
REQ-008 addr_ready  out  1  block accepts a beat.
REQ-009 desc_ini  out  W  first address of the sequence.
REQ-010 desc_fin  out  W  last address of the sequence.
REQ-011 desc_param  out  W  stride, beat2 minus beat1, modulo 2^W.
REQ-012 desc_len  out  LW  beats in the sequence.
REQ-013 desc_err  out  1  sequence was not a constant-stride progression.
REQ-014 desc_valid  out  1  descriptor valid.
REQ-015 desc_ready  in  1  downstream accepts descriptor.

Function
REQ-016 Block SHALL compress an address stream back into the (ini, fin, param) descriptor that regenerates it; it is the inverse of the address generator.
REQ-017 Beat accepted SHALL be defined as addr_valid & addr_ready; descriptor transfer SHALL be defined as desc_valid & desc_ready.
REQ-018 FSM SHALL have states FIRST, SECOND, RUN, OUT.
REQ-019 addr_ready SHALL be 1 in FIRST, SECOND and RUN, and SHALL be 0 in OUT; it SHALL be decoded from state only.
REQ-020 FIRST, beat accepted: ini<=addr, prev<=addr, len<=1, err<=0, param<=0.
REQ-021 FIRST, beat accepted with addr_last=1: go to OUT, fin=ini, param=0, len=1.
REQ-022 FIRST, beat accepted with addr_last=0: go to SECOND.
REQ-023 SECOND, beat accepted: param<=addr-prev (mod 2^W), prev<=addr, len+1.
REQ-024 SECOND, beat accepted: go to OUT if addr_last=1, else go to RUN.
REQ-025 RUN, beat accepted: if addr != prev+param (mod 2^W), set err, sticky until the descriptor is consumed.
REQ-026 RUN, beat accepted: prev<=addr, len+1.
REQ-027 RUN, beat accepted: go to OUT if addr_last=1.
REQ-028 On mismatch, param SHALL keep the first-pair stride.
REQ-029 fin SHALL always equal the address of the last accepted beat.
REQ-030 len SHALL saturate at 2^LW-1 and SHALL NOT wrap.
REQ-031 Zero stride (repeated address) SHALL be legal, with err=0.
REQ-032 Stride arithmetic SHALL wrap modulo 2^W, so progressions crossing 0 SHALL have err=0.
REQ-033 desc_* outputs SHALL be registered.
REQ-034 desc_valid SHALL rise the cycle after the last beat is accepted (latency 1).
REQ-035 In OUT, desc_* SHALL hold stable until transfer.
REQ-036 On transfer, FSM SHALL go to FIRST, desc_valid<=0 and addr_ready=1 from the next cycle; no same-cycle bypass.
REQ-037 Beats with addr_valid=0 SHALL cause no state change, and gaps between beats SHALL be allowed.

Reset
REQ-038 rst SHALL force: state FIRST, desc_valid=0, desc_ini/fin/param=0, desc_len=0, desc_err=0, internal prev/len cleared.
REQ-039 Consequence of REQ-038: addr_ready=1 the cycle after rst deasserts.
REQ-040 rst mid-sequence or in OUT SHALL discard the partial or pending descriptor without emitting it.
REQ-041 rst SHALL take priority over all handshakes in the same cycle.

Verification
REQ-042 Beats 0x10,0x14,0x18,0x1C (last on 0x1C), desc_ready=1 -> one descriptor: ini=0x10 fin=0x1C param=4 len=4 err=0, desc_valid asserted one cycle after last.
REQ-043 Single beat 0x100 with last -> ini=fin=0x100 param=0 len=1 err=0.
REQ-044 Beats 0,4,8,0x20 (last) -> ini=0 fin=0x20 param=4 len=4 err=1; next sequence 8,8 (last) -> param=0 err=0 (err cleared).
REQ-045 Beats 0xFFFFFFF8,0xFFFFFFFC,0x0 (last) -> param=4 fin=0 len=3 err=0.
REQ-046 desc_ready held 0 for 3 cycles in OUT, with addr_valid=1 -> addr_ready=0, descriptor bits unchanged, no beat consumed; after transfer, next beat starts a new descriptor.
REQ-047 rst asserted after 2 beats of a sequence -> no descriptor emitted; following sequence 0x40,0x48 (last) -> ini=0x40 param=8 len=2.
